taylor_seq_ctrl: RTL and testbench
==================================

TAYLOR_SEQ_CTRL -- requirements
Module: taylor_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 3: width of term counter and n_terms.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a series evaluation; sampled only in IDLE.
REQ-005 abort  input  1  cancel the evaluation in progress; sampled in INIT, MUL and ADD.
REQ-006 n_terms  input  CNT_W  number of series terms; captured when start is accepted.
REQ-007 busy  output  1  high in INIT, MUL and ADD.
REQ-008 done  output  1  one-cycle pulse in DONE.
REQ-009 ldX  output  1  load input register x.
REQ-010 ldTmp  output  1  load term register.
REQ-011 selTmp  output  1  term-register mux: 1 = constant 1.0, 0 = multiplier output.
REQ-012 clrAcc  output  1  synchronous clear of the accumulator.
REQ-013 ldAcc  output  1  accumulator load of acc + tmp.
REQ-014 selCoef  output  CNT_W  coefficient-ROM index, equal to the term counter.

Function
REQ-015 States: IDLE, INIT, MUL, ADD and DONE, with Moore outputs decoded from the present state only.
REQ-016 Outputs in IDLE: all control outputs 0; busy=0; done=0.
REQ-017 Transition from IDLE: IDLE goes to INIT when start=1; otherwise it stays in IDLE.
REQ-018 Capture on start acceptance: n_terms is latched into nreg.
REQ-019 Outputs in INIT (one cycle): ldX=1, ldTmp=1, selTmp=1, clrAcc=1; the counter is cleared to 0.
REQ-020 Transition from INIT: INIT goes to DONE when nreg=0; otherwise it goes to MUL.
REQ-021 Outputs in MUL (one cycle): ldTmp=1, selTmp=0; tmp is loaded with tmp*x*coef[selCoef].
REQ-022 Outputs in ADD (one cycle): ldAcc=1.
REQ-023 Transition from ADD: ADD goes to DONE when cnt=nreg-1; otherwise cnt increments and ADD goes to MUL.
REQ-024 Outputs in DONE (one cycle): done=1, busy=0.
REQ-025 Transition from DONE: DONE goes unconditionally to IDLE.
REQ-026 Start while not in IDLE: start is ignored in every state other than IDLE, including DONE.
REQ-027 Latency: with start=1 in IDLE at cycle 0, done=1 in cycle 2*nreg+2 (nreg=0 gives cycle 2; nreg=7 gives cycle 16).
REQ-028 Abort in INIT, MUL or ADD: the next state is IDLE; done is not pulsed; no ldAcc is issued in the aborting cycle's successor.
REQ-029 Abort priority: abort has priority over every other transition out of INIT, MUL and ADD.
REQ-030 Counter range: cnt never exceeds nreg-1, so no wrap-around occurs.
REQ-031 Counter width: cnt is CNT_W bits wide, which suffices for the maximum nreg of 2^CNT_W-1.
REQ-032 Input stability: n_terms changes after acceptance have no effect until the next accepted start.

Reset
REQ-033 While rst=1 at a clock edge, the state becomes IDLE, cnt=0 and nreg=0.
REQ-034 Reset overrides start and abort.
REQ-035 Reset mid-operation returns the block to IDLE on the next edge with all outputs 0 and no done pulse.

Structure
REQ-036 The state encodings (3-bit; IDLE=0, INIT=1, MUL=2, ADD=3, DONE=4) are constants in the shared package ctrl_pkg.
REQ-037 ctrl_pkg also holds the default CNT_W.
REQ-038 The counter is one sub-module, term_counter, with ports clk, rst, clr, inc, count and a terminal-compare output.
REQ-039 Unused state encodings 5-7 go to IDLE with all outputs 0.

Verification
REQ-040 Scenario: rst high for 2 cycles, then low -> all outputs 0, busy=0, and the state is IDLE.
REQ-041 Scenario: n_terms=3, one-cycle start -> INIT, then three MUL/ADD pairs with selCoef=0,1,2; done=1 exactly in cycle 8; busy=1 in cycles 1-7.
REQ-042 Scenario: n_terms=0, start -> INIT (clrAcc=1) in cycle 1, done in cycle 2; no MUL or ADD is entered.
REQ-043 Scenario: n_terms=5, start; abort=1 in cycle 5 (an ADD) -> IDLE in cycle 6, no done pulse, and no ldAcc after cycle 5.
REQ-044 Scenario: n_terms=2, start held high continuously and n_terms changed to 6 mid-run -> done in cycle 6; a new run is accepted only from the IDLE cycle that follows DONE.
REQ-045 Scenario: n_terms=7, rst=1 asserted in cycle 9 -> IDLE in cycle 10, all outputs 0, no done pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared state encodings, default counter width and Moore output decode
// for the Taylor-series sequencing controller.
package ctrl_pkg;

   localparam int CNT_W_DEF = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      MUL  = 3'd2,
      ADD  = 3'd3,
      DONE = 3'd4
   } state_t;

   typedef struct packed {
      logic busy;
      logic done;
      logic ld_x;
      logic ld_tmp;
      logic sel_tmp;
      logic clr_acc;
      logic ld_acc;
      logic coef_en;
   } ctrl_out_t;

   // coef_en gates the counter onto selCoef so idle/done states present index 0
   function automatic ctrl_out_t decode_state(state_t s);
      ctrl_out_t o;
      o = '0;
      case (s)
         INIT: begin
            o.busy    = 1'b1;
            o.ld_x    = 1'b1;
            o.ld_tmp  = 1'b1;
            o.sel_tmp = 1'b1;
            o.clr_acc = 1'b1;
         end
         MUL: begin
            o.busy    = 1'b1;
            o.ld_tmp  = 1'b1;
            o.coef_en = 1'b1;
         end
         ADD: begin
            o.busy    = 1'b1;
            o.ld_acc  = 1'b1;
            o.coef_en = 1'b1;
         end
         DONE:    o.done = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/taylor_seq_ctrl_if.sv
// Handshake and datapath-control bundle between a requester (master)
// and the series controller (slave).
interface taylor_seq_ctrl_if #(
   parameter int CNT_W = ctrl_pkg::CNT_W_DEF
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] n_terms;
   logic             busy;
   logic             done;
   logic             ldX;
   logic             ldTmp;
   logic             selTmp;
   logic             clrAcc;
   logic             ldAcc;
   logic [CNT_W-1:0] selCoef;

   modport master (
      output start, abort, n_terms,
      input  busy, done, ldX, ldTmp, selTmp, clrAcc, ldAcc, selCoef
   );

   modport slave (
      input  start, abort, n_terms,
      output busy, done, ldX, ldTmp, selTmp, clrAcc, ldAcc, selCoef
   );
endinterface

// File: rtl/term_counter.sv
// Term index counter with synchronous clear/increment and a flag that is
// high when the count has reached limit-1 (the last term).
module term_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         last
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= '0;
      else if (clr)
         count_reg <= '0;
      else if (inc)
         count_reg <= count_reg + W'(1);
   end

   assign count = count_reg;
   assign last  = (count_reg == limit - W'(1));

endmodule

// File: rtl/taylor_seq_ctrl.sv
// Sequencer for a Taylor-series datapath: INIT, then n MUL/ADD pairs, then a
// one-cycle DONE pulse. Outputs are registered from the next-state decode.
module taylor_seq_ctrl
   import ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input logic              clk,
   input logic              rst,
   taylor_seq_ctrl_if.slave bus
);

   state_t           state_reg;
   state_t           state_next;
   ctrl_out_t        out_reg;
   logic [CNT_W-1:0] nreg_reg;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             cnt_clr;
   logic             cnt_inc;

   // abort is checked first so it wins over every other exit from a busy state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = INIT;
         INIT:    if (bus.abort) state_next = IDLE;
                  else if (nreg_reg == '0) state_next = DONE;
                  else state_next = MUL;
         MUL:     if (bus.abort) state_next = IDLE;
                  else state_next = ADD;
         ADD:     if (bus.abort) state_next = IDLE;
                  else if (cnt_last) state_next = DONE;
                  else state_next = MUL;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign cnt_clr = (state_next == INIT) || (state_next == IDLE);
   assign cnt_inc = (state_reg == ADD) && (state_next == MUL);

   term_counter #(.W(CNT_W)) u_term_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .limit (nreg_reg),
      .count (cnt),
      .last  (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         out_reg   <= '0;
         nreg_reg  <= '0;
      end else begin
         state_reg <= state_next;
         out_reg   <= decode_state(state_next);
         if (state_reg == IDLE && bus.start)
            nreg_reg <= bus.n_terms;
      end
   end

   assign bus.busy    = out_reg.busy;
   assign bus.done    = out_reg.done;
   assign bus.ldX     = out_reg.ld_x;
   assign bus.ldTmp   = out_reg.ld_tmp;
   assign bus.selTmp  = out_reg.sel_tmp;
   assign bus.clrAcc  = out_reg.clr_acc;
   assign bus.ldAcc   = out_reg.ld_acc;
   assign bus.selCoef = out_reg.coef_en ? cnt : '0;

endmodule

// File: tb/tb_taylor_seq_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// timeline model: a run accepted at cycle t0 with n terms is described by k=cyc-t0.
module tb_taylor_seq_ctrl;

   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   taylor_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

   taylor_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;

   bit m_active = 1'b0;
   int m_t0     = 0;
   int m_n      = 0;
   int m_cyc    = 0;

   task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s cycle %0d: got %b expected %b (busy,done,ldX,ldTmp,selTmp,clrAcc,ldAcc,selCoef)",
                  tag, m_cyc, obs, exp);
      end
   endtask

   function automatic logic [9:0] observed();
      return {bus.busy, bus.done, bus.ldX, bus.ldTmp, bus.selTmp,
              bus.clrAcc, bus.ldAcc, bus.selCoef};
   endfunction

   // k=1 INIT, k=2..2n+1 alternating MUL (even) / ADD (odd), k=2n+2 DONE
   function automatic logic [9:0] expected();
      int   k;
      logic busy, done, first, mul, add;
      logic [CNT_W-1:0] coef;
      if (!m_active) return '0;
      k     = m_cyc - m_t0;
      busy  = (k >= 1) && (k <= 2 * m_n + 1);
      done  = (k == 2 * m_n + 2);
      first = (k == 1);
      mul   = (k >= 2) && (k <= 2 * m_n + 1) && (k % 2 == 0);
      add   = (k >= 3) && (k <= 2 * m_n + 1) && (k % 2 == 1);
      coef  = (mul || add) ? CNT_W'((k - 2) / 2) : '0;
      return {busy, done, first, first | mul, first, first, add, coef};
   endfunction

   task automatic tick(input string tag);
      int k;
      @(posedge clk);
      if (rst) begin
         if (m_active) $display("run n=%0d t0=%0d: reset at cycle %0d", m_n, m_t0, m_cyc);
         m_active = 1'b0;
      end else if (m_active) begin
         k = m_cyc - m_t0;
         if (k <= 2 * m_n + 1 && bus.abort) begin
            $display("run n=%0d t0=%0d: aborted at cycle %0d", m_n, m_t0, m_cyc);
            m_active = 1'b0;
         end else if (k == 2 * m_n + 2) begin
            $display("run n=%0d t0=%0d: done at cycle %0d", m_n, m_t0, m_cyc);
            m_active = 1'b0;
         end
      end else if (bus.start) begin
         m_active = 1'b1;
         m_t0     = m_cyc;
         m_n      = int'(bus.n_terms);
      end
      m_cyc++;
      #1;
      check_eq(tag, observed(), expected());
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.n_terms = '0;

      ticks("reset", 2);
      rst = 1'b0;
      ticks("post_reset", 2);

      bus.n_terms = 3'd3; bus.start = 1'b1;
      tick("n3_start");
      bus.start = 1'b0;
      ticks("n3_run", 10);

      bus.n_terms = 3'd0; bus.start = 1'b1;
      tick("n0_start");
      bus.start = 1'b0;
      ticks("n0_run", 4);

      bus.n_terms = 3'd5; bus.start = 1'b1;
      tick("n5_start");
      bus.start = 1'b0;
      ticks("n5_run", 4);
      bus.abort = 1'b1;
      tick("n5_abort");
      bus.abort = 1'b0;
      ticks("n5_after", 6);

      bus.n_terms = 3'd2; bus.start = 1'b1;
      tick("hold_start");
      ticks("hold_run", 3);
      bus.n_terms = 3'd6;
      ticks("hold_change", 10);
      bus.start = 1'b0;
      ticks("hold_drain", 16);

      bus.n_terms = 3'd7; bus.start = 1'b1;
      tick("n7_start");
      bus.start = 1'b0;
      ticks("n7_run", 8);
      rst = 1'b1;
      tick("n7_reset");
      rst = 1'b0;
      ticks("n7_after", 4);

      bus.n_terms = 3'd7; bus.start = 1'b1;
      tick("n7_full_start");
      bus.start = 1'b0;
      ticks("n7_full_run", 17);

      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 149) == 0);
         bus.start   = ($urandom_range(0, 3) == 0);
         bus.abort   = ($urandom_range(0, 24) == 0);
         bus.n_terms = CNT_W'($urandom_range(0, 7));
         tick("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
